branch_update_ctrl: RTL and testbench
=====================================

BRANCH_UPDATE_CTRL -- requirements
Module: branch_update_ctrl

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 5, predictor counter-array index width (2^INDEX_BITS entries).
REQ-002 SHALL have parameter QDEPTH, default 4, update-queue depth (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports wb_valid/wb_taken/wb_predicted  input  1 each  resolved conditional branch at WB, actual outcome, prediction carried down the pipe.
REQ-006 SHALL have port wb_index  input  INDEX_BITS  counter index of the resolved branch (history-hashed upstream).
REQ-007 SHALL have port wb_ready  output  1  update queue accepts an entry this cycle.
REQ-008 SHALL have port clear_req  input  1  request to re-initialise all counters.
REQ-009 SHALL have port upd_hold  input  1  suppresses issue of new counter reads.
REQ-010 SHALL have ports arr_rindex  output  INDEX_BITS  and arr_rdata  input  2  synchronous-read array port; data valid one cycle after index.
REQ-011 SHALL have ports arr_write  output  1, arr_windex  output  INDEX_BITS, arr_wdata  output  2  array write port.
REQ-012 SHALL have ports init_busy  output  1  and mispredict  output  1  (one-cycle pulse).
REQ-013 SHALL have ports stat_branches, stat_mispredicts  output  16 each.

Function
REQ-014 SHALL implement states INIT and RUN.
REQ-015 INIT: one write per cycle, arr_windex = sweep counter 0..2^INDEX_BITS-1, arr_wdata = 2'b01 (weakly not taken), init_busy = 1, wb_ready = 0.
REQ-016 After writing the last index, SHALL enter RUN; wb_ready may assert the following cycle.
REQ-017 wb_ready SHALL be 1 only in RUN with queue not full; push occurs when wb_valid & wb_ready; wb_valid with wb_ready = 0 is dropped by contract (upstream stalls).
REQ-018 Queue entry = {index, taken}; FIFO order; pushed entry eligible for issue the next cycle.
REQ-019 Issue stage: in RUN, queue non-empty and upd_hold = 0 -> pop head, drive arr_rindex = head index; one issue per cycle.
REQ-020 Write stage (cycle after issue): arr_write = 1, arr_windex = issued index, arr_wdata = 2-bit saturating update of read value (+1 if taken, -1 if not; saturate at 00 and 11).
REQ-021 Hazard: if the write-stage index equals the entry written in the immediately preceding cycle, SHALL use that written value instead of arr_rdata.
REQ-022 upd_hold SHALL not cancel an issue already in the write stage.
REQ-023 mispredict SHALL pulse the cycle after a push with wb_taken != wb_predicted.
REQ-024 clear_req in RUN: SHALL discard queue and in-flight write, enter INIT at sweep index 0 next cycle; clear_req during INIT restarts the sweep at 0.
REQ-025 Push and pop in the same cycle SHALL both take effect; occupancy unchanged.

Reset
REQ-026 On reset assertion: state INIT, sweep counter 0, queue empty, write stage empty; arr_write 0, mispredict 0, wb_ready 0, init_busy 1, stat outputs 0.
REQ-027 Reset asserted mid-sweep or mid-update SHALL abandon all work; sweep restarts at index 0 after release.

Configuration
REQ-028 Macro BP_STATS_EN defined: stat_branches counts accepted pushes, stat_mispredicts counts mispredict pulses; both saturate at 16'hFFFF, clear on reset and clear_req.
REQ-029 BP_STATS_EN undefined: counters not built; both stat ports tied to 0.

Structure
REQ-030 Saturating-update function, state enum and 2'b01 init constant SHALL live in lc3b_types.
REQ-031 Queue SHALL be a sub-module bp_update_fifo (parameterised width, depth; push/pop/full/empty).

Verification
REQ-032 Reset release, INDEX_BITS=5: 32 cycles of arr_write with windex 0..31, wdata 01, init_busy 1; wb_ready = 1 on cycle 33.
REQ-033 Push index 7, taken=1, predicted=0; arr_rdata=01 -> arr_rindex 7 next cycle, write 10 to index 7 the cycle after; mispredict pulses once.
REQ-034 Saturation: rdata 11 with taken -> wdata 11; rdata 00 with not-taken -> wdata 00.
REQ-035 Back-to-back pushes to index 3, both taken, initial 01 -> writes 10 then 11 (forwarded, ignoring stale arr_rdata).
REQ-036 upd_hold = 1 while pushing 4 entries -> wb_ready drops after 4th; release hold -> 4 writes in push order, wb_ready re-asserts.
REQ-037 clear_req with 2 queued entries -> no update writes, INIT sweep from index 0; BP_STATS_EN counters read 0.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types and helpers for the branch predictor update path:
// controller state encoding, counter init value, stats ceiling and the
// 2-bit saturating counter update.
package lc3b_types;

    // Controller state: INIT sweeps the counter array, RUN services updates.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    // Every counter starts as weakly not taken.
    localparam logic [1:0] BP_CTR_INIT = 2'b01;

    // Ceiling for the optional 16-bit statistics counters.
    localparam logic [15:0] BP_STAT_MAX = 16'hFFFF;

    // Move a 2-bit counter one step toward the actual outcome, holding at 00/11.
    function automatic logic [1:0] bp_sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] v_next;
        v_next = ctr;
        if (taken) begin
            if (ctr != 2'b11) v_next = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) v_next = ctr - 2'd1;
        end
        return v_next;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Small synchronous FIFO holding resolved-branch update entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A flush empties the queue in one cycle; push and pop may coincide.
module bp_update_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_pdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rptr[AW-1:0]];

    // Advance pointers on push/pop; flush drops every stored entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_pdata;
    end

endmodule

// File: rtl/branch_update_ctrl.sv
// Branch predictor update controller.
// After reset (or a clear request) it sweeps the 2-bit counter array to
// weakly-not-taken, then accepts resolved branches into a small queue and
// applies read-modify-write saturating updates through a synchronous-read
// array port, forwarding the previous cycle's write on an index match.
// Optional build macro BP_STATS_EN adds saturating branch/mispredict counters.
//
// Handshake: an entry is accepted on a rising clk edge exactly when
// wb_valid && wb_ready; wb_ready does not depend on wb_valid, and a
// wb_valid presented while wb_ready is low is not accepted (upstream stalls).
module branch_update_ctrl
    import lc3b_types::*;
#(
    parameter int INDEX_BITS = 5,
    parameter int QDEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic                  wb_taken,
    input  logic                  wb_predicted,
    input  logic [INDEX_BITS-1:0] wb_index,
    output logic                  wb_ready,
    input  logic                  clear_req,
    input  logic                  upd_hold,
    output logic [INDEX_BITS-1:0] arr_rindex,
    input  logic [1:0]            arr_rdata,
    output logic                  arr_write,
    output logic [INDEX_BITS-1:0] arr_windex,
    output logic [1:0]            arr_wdata,
    output logic                  init_busy,
    output logic                  mispredict,
    output logic [15:0]           stat_branches,
    output logic [15:0]           stat_mispredicts,
    output bp_state_e             o_dbg_state
);

    localparam int QW = INDEX_BITS + 1;
    localparam logic [INDEX_BITS-1:0] SWEEP_LAST = '1;
    localparam logic [INDEX_BITS-1:0] SWEEP_ONE  = {{(INDEX_BITS-1){1'b0}}, 1'b1};

    bp_state_e             r_state;
    bp_state_e             w_state_next;
    logic [INDEX_BITS-1:0] r_sweep;

    logic                  w_push;
    logic                  w_issue;
    logic [QW-1:0]         w_q_head;
    logic                  w_q_full;
    logic                  w_q_empty;

    logic                  r_ws_valid;
    logic [INDEX_BITS-1:0] r_ws_index;
    logic                  r_ws_taken;

    logic                  r_lw_valid;
    logic [INDEX_BITS-1:0] r_lw_index;
    logic [1:0]            r_lw_data;

    logic [1:0]            w_old_ctr;
    logic                  r_mispredict;

    assign w_push      = wb_valid & wb_ready;
    assign arr_rindex  = w_q_head[QW-1:1];
    assign mispredict  = r_mispredict;
    assign o_dbg_state = r_state;

    // The array has not yet absorbed last cycle's write when it was read, so
    // a same-index write from the preceding cycle overrides the read data.
    assign w_old_ctr = (r_lw_valid && (r_lw_index == r_ws_index)) ? r_lw_data : arr_rdata;

    bp_update_fifo #(
        .WIDTH (QW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_flush (clear_req),
        .i_push  (w_push),
        .i_pdata ({wb_index, wb_taken}),
        .i_pop   (w_issue),
        .o_head  (w_q_head),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_INIT;
        else        r_state <= w_state_next;
    end

    // Next state, handshake, issue and array write port.
    always_comb begin
        w_state_next = r_state;
        wb_ready     = 1'b0;
        init_busy    = 1'b0;
        w_issue      = 1'b0;
        arr_write    = 1'b0;
        arr_windex   = r_ws_index;
        arr_wdata    = bp_sat_update(w_old_ctr, r_ws_taken);
        case (r_state)
            ST_INIT: begin
                init_busy  = 1'b1;
                // No sweep write while reset is held low.
                arr_write  = reset;
                arr_windex = r_sweep;
                arr_wdata  = BP_CTR_INIT;
                if (!clear_req && (r_sweep == SWEEP_LAST)) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                wb_ready  = ~w_q_full;
                w_issue   = ~w_q_empty & ~upd_hold & ~clear_req;
                // A clear discards the write that is already in flight.
                arr_write = r_ws_valid & ~clear_req;
                if (clear_req) w_state_next = ST_INIT;
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    // Sweep index: counts only while sweeping; a clear restarts it at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sweep <= '0;
        end else if ((r_state == ST_INIT) && !clear_req) begin
            r_sweep <= r_sweep + SWEEP_ONE;
        end else begin
            r_sweep <= '0;
        end
    end

    // Write stage: captures the entry popped this cycle for next cycle's write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ws_valid <= 1'b0;
            r_ws_index <= '0;
            r_ws_taken <= 1'b0;
        end else begin
            r_ws_valid <= w_issue;
            r_ws_index <= w_q_head[QW-1:1];
            r_ws_taken <= w_q_head[0];
        end
    end

    // Last-write record used for read-after-write forwarding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lw_valid <= 1'b0;
            r_lw_index <= '0;
            r_lw_data  <= 2'b00;
        end else begin
            r_lw_valid <= arr_write;
            r_lw_index <= arr_windex;
            r_lw_data  <= arr_wdata;
        end
    end

    // One-cycle mispredict pulse after an accepted wrong prediction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_mispredict <= 1'b0;
        else        r_mispredict <= w_push & (wb_taken ^ wb_predicted);
    end

`ifdef BP_STATS_EN
    logic [15:0] r_stat_br;
    logic [15:0] r_stat_mp;

    // Saturating counts of accepted branches and mispredict pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_br <= 16'h0000;
            r_stat_mp <= 16'h0000;
        end else if (clear_req) begin
            r_stat_br <= 16'h0000;
            r_stat_mp <= 16'h0000;
        end else begin
            if (w_push && (r_stat_br != BP_STAT_MAX))       r_stat_br <= r_stat_br + 16'd1;
            if (r_mispredict && (r_stat_mp != BP_STAT_MAX)) r_stat_mp <= r_stat_mp + 16'd1;
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mp;
`else
    assign stat_branches    = 16'h0000;
    assign stat_mispredicts = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Directed testbench for branch_update_ctrl with a synchronous-read
// counter array model and an expected-write scoreboard.
module tb_branch_update_ctrl;
  import lc3b_types::*;

  localparam int IB = 5;
  localparam int W  = IB + 2;

`ifdef BP_STATS_EN
  localparam logic [15:0] EXP_BR = 16'd11;
  localparam logic [15:0] EXP_MP = 16'd2;
`else
  localparam logic [15:0] EXP_BR = 16'd0;
  localparam logic [15:0] EXP_MP = 16'd0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          wb_valid, wb_taken, wb_predicted;
  logic [IB-1:0] wb_index;
  logic          wb_ready;
  logic          clear_req, upd_hold;
  logic [IB-1:0] arr_rindex;
  logic [1:0]    arr_rdata;
  logic          arr_write;
  logic [IB-1:0] arr_windex;
  logic [1:0]    arr_wdata;
  logic          init_busy, mispredict;
  logic [15:0]   stat_branches, stat_mispredicts;
  bp_state_e     dbg_state;

  branch_update_ctrl #(.INDEX_BITS(IB), .QDEPTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .wb_valid         (wb_valid),
    .wb_taken         (wb_taken),
    .wb_predicted     (wb_predicted),
    .wb_index         (wb_index),
    .wb_ready         (wb_ready),
    .clear_req        (clear_req),
    .upd_hold         (upd_hold),
    .arr_rindex       (arr_rindex),
    .arr_rdata        (arr_rdata),
    .arr_write        (arr_write),
    .arr_windex       (arr_windex),
    .arr_wdata        (arr_wdata),
    .init_busy        (init_busy),
    .mispredict       (mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts),
    .o_dbg_state      (dbg_state)
  );

  // counter array model: read data one cycle after index, read-before-write
  logic [1:0] mem [32];
  logic [1:0] mem_rdata;
  logic       rd_ovr_en;
  logic [1:0] rd_ovr_val;
  always @(posedge clk) begin
    mem_rdata <= mem[arr_rindex];
    if (arr_write) mem[arr_windex] <= arr_wdata;
  end
  assign arr_rdata = rd_ovr_en ? rd_ovr_val : mem_rdata;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // every update write (outside the init sweep) must match the expected queue
  always @(negedge clk) begin
    if (mon_en && arr_write && !init_busy) begin
      if (exp_q.size() == 0) check("spurious_write", 32'({arr_windex, arr_wdata}), 32'hFFFF_FFFF);
      else check("update_write", 32'({arr_windex, arr_wdata}), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks (inputs change 1 time unit after the rising edge)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [IB-1:0] idx, input logic t, input logic p);
    wb_valid = 1'b1; wb_index = idx; wb_taken = t; wb_predicted = p;
    @(negedge clk);
    check("push_ready", 32'(wb_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int n = 0; n < max_cyc; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  task automatic wait_ready(input int max_cyc);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      if (wb_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("wait_ready", 32'(seen), 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    check("watchdog", 32'd0, 32'd1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    reset = 1'b0; wb_valid = 1'b0; wb_taken = 1'b0; wb_predicted = 1'b0; wb_index = '0;
    clear_req = 1'b0; upd_hold = 1'b0; rd_ovr_en = 1'b0; rd_ovr_val = 2'b00;
    for (int i = 0; i < 32; i++) mem[i] = 2'b11;

    // reset state
    repeat (2) begin
      @(negedge clk);
      check("rst_arr_write", 32'(arr_write), 32'd0);
      check("rst_init_busy", 32'(init_busy), 32'd1);
      check("rst_wb_ready", 32'(wb_ready), 32'd0);
      check("rst_mispredict", 32'(mispredict), 32'd0);
      check("rst_stat_br", 32'(stat_branches), 32'd0);
      check("rst_stat_mp", 32'(stat_mispredicts), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_INIT));
    end
    @(posedge clk); #1;
    reset = 1'b1;

    // init sweep: 32 writes of 01, then ready
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("init_write", 32'(arr_write), 32'd1);
      check("init_windex", 32'(arr_windex), 32'(i));
      check("init_wdata", 32'(arr_wdata), 32'd1);
      check("init_busy", 32'(init_busy), 32'd1);
      check("init_ready", 32'(wb_ready), 32'd0);
    end
    @(negedge clk);
    check("run_ready", 32'(wb_ready), 32'd1);
    check("run_busy", 32'(init_busy), 32'd0);
    check("run_nowrite", 32'(arr_write), 32'd0);
    check("run_state", 32'(dbg_state), 32'(ST_RUN));
    tick();
    mon_en = 1'b1;

    // basic update with mispredict: index 7, 01 -> 10
    exp_q.push_back({5'd7, 2'b10});
    push_one(5'd7, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_rindex", 32'(arr_rindex), 32'd7);
    check("t1_mispredict", 32'(mispredict), 32'd1);
    tick();
    @(negedge clk);
    check("t1_write", 32'(arr_write), 32'd1);
    check("t1_windex", 32'(arr_windex), 32'd7);
    check("t1_wdata", 32'(arr_wdata), 32'd2);
    check("t1_pulse_end", 32'(mispredict), 32'd0);
    tick();
    wait_drain(10);

    // saturation at both ends using forced read data
    rd_ovr_en = 1'b1; rd_ovr_val = 2'b11;
    exp_q.push_back({5'd12, 2'b11});
    push_one(5'd12, 1'b1, 1'b1);
    @(negedge clk);
    check("t2_no_mispredict", 32'(mispredict), 32'd0);
    tick();
    @(negedge clk);
    check("t2_sat_hi", 32'(arr_wdata), 32'd3);
    tick();
    rd_ovr_val = 2'b00;
    exp_q.push_back({5'd13, 2'b00});
    push_one(5'd13, 1'b0, 1'b1);
    @(negedge clk);
    check("t2_mispredict", 32'(mispredict), 32'd1);
    tick();
    @(negedge clk);
    check("t2_sat_lo", 32'(arr_wdata), 32'd0);
    tick();
    rd_ovr_en = 1'b0;
    wait_drain(10);

    // back-to-back same index: second write forwards 10 -> 11
    exp_q.push_back({5'd3, 2'b10});
    exp_q.push_back({5'd3, 2'b11});
    push_one(5'd3, 1'b1, 1'b1);
    push_one(5'd3, 1'b1, 1'b1);
    wait_drain(10);

    // hold fills the queue, release drains in order
    upd_hold = 1'b1;
    exp_q.push_back({5'd20, 2'b10});
    exp_q.push_back({5'd21, 2'b00});
    exp_q.push_back({5'd22, 2'b10});
    exp_q.push_back({5'd23, 2'b10});
    push_one(5'd20, 1'b1, 1'b1);
    push_one(5'd21, 1'b0, 1'b0);
    push_one(5'd22, 1'b1, 1'b1);
    push_one(5'd23, 1'b1, 1'b1);
    @(negedge clk);
    check("t4_full_ready", 32'(wb_ready), 32'd0);
    check("t4_hold_nowrite", 32'(arr_write), 32'd0);
    tick();
    upd_hold = 1'b0;
    @(negedge clk);
    check("t4_still_full", 32'(wb_ready), 32'd0);
    check("t4_first_rindex", 32'(arr_rindex), 32'd20);
    tick();
    @(negedge clk);
    check("t4_ready_back", 32'(wb_ready), 32'd1);
    tick();
    wait_drain(10);

    // clear with two queued entries
    upd_hold = 1'b1;
    push_one(5'd5, 1'b1, 1'b1);
    push_one(5'd6, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_stat_br", 32'(stat_branches), 32'(EXP_BR));
    check("t5_stat_mp", 32'(stat_mispredicts), 32'(EXP_MP));
    tick();
    clear_req = 1'b1;
    @(negedge clk);
    check("t5_clear_nowrite", 32'(arr_write), 32'd0);
    tick();
    clear_req = 1'b0;
    upd_hold = 1'b0;
    @(negedge clk);
    check("t5_init_busy", 32'(init_busy), 32'd1);
    check("t5_init_windex", 32'(arr_windex), 32'd0);
    check("t5_init_wdata", 32'(arr_wdata), 32'd1);
    check("t5_init_ready", 32'(wb_ready), 32'd0);
    check("t5_stat_br_clr", 32'(stat_branches), 32'd0);
    check("t5_stat_mp_clr", 32'(stat_mispredicts), 32'd0);
    tick();
    wait_ready(40);
    repeat (4) tick();
    check("t5_no_updates", 32'(exp_q.size()), 32'd0);

    // clear discards an update already in the write stage
    push_one(5'd9, 1'b1, 1'b1);
    tick();
    clear_req = 1'b1;
    @(negedge clk);
    check("t6_inflight_dropped", 32'(arr_write), 32'd0);
    tick();
    clear_req = 1'b0;
    @(negedge clk);
    check("t6_init_windex", 32'(arr_windex), 32'd0);
    tick();

    // reset mid-sweep restarts at index 0
    repeat (4) tick();
    reset = 1'b0;
    @(negedge clk);
    check("t7_rst_nowrite", 32'(arr_write), 32'd0);
    check("t7_rst_busy", 32'(init_busy), 32'd1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("t7_restart_write", 32'(arr_write), 32'd1);
    check("t7_restart_windex", 32'(arr_windex), 32'd0);
    tick();
    wait_ready(40);
    check("t7_state_run", 32'(dbg_state), 32'(ST_RUN));
    repeat (3) tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
